bram_prog_loader: RTL and testbench

//  Byte-stream writer for the shared instruction/data BRAM. It receives a framed program image over a valid/ready byte stream.
//  It packs bytes into 32-bit little-endian words and drives the BRAM write port (NB_COL byte enables).
//  It holds the barrel-threaded core in reset until a frame's checksum verifies. Sits between the host link and the BRAM port A.

---
 rtl/bram_prog_loader_pkg.sv | 18 +
 rtl/bram_prog_loader.sv | 154 +++++++++++++++
 tb/tb_bram_prog_loader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_prog_loader_pkg.sv
// Shared types and constants for the BRAM program loader.
// The state enum and sync marker are also what the surrounding riscv_pkg exports.
package bram_prog_loader_pkg;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN_LO,
        LD_LEN_HI,
        LD_DATA,
        LD_WRITE,
        LD_CSUM,
        LD_DONE,
        LD_ERR
    } loader_state_t;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;

endpackage

// File: rtl/bram_prog_loader.sv
// Framed byte-stream to BRAM word writer; keeps the core in reset until
// a frame's XOR checksum verifies.
module bram_prog_loader
    import bram_prog_loader_pkg::*;
#(
    parameter int                ADDR_WIDTH = 10,
    parameter int                MEM_WORDS  = 1024,
    parameter int                NB_COL     = 4,
    parameter int                COL_WIDTH  = 8,
    parameter logic [COL_WIDTH-1:0] SYNC_BYTE = LOADER_SYNC
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [COL_WIDTH-1:0]          s_data_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    output logic [NB_COL-1:0]             mem_we_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [NB_COL*COL_WIDTH-1:0]   mem_wdata_o,
    output logic                          core_rst_o,
    output logic                          done_o,
    output logic                          err_o
);

    localparam int WORD_W = NB_COL * COL_WIDTH;
    localparam logic [16:0] MAX_LEN = 17'(MEM_WORDS);

    loader_state_t                 state_q;
    logic [15:0]                   len_q;
    logic [COL_WIDTH-1:0]          csum_q;
    logic [1:0]                    bcnt_q;
    logic [WORD_W-COL_WIDTH-1:0]   pack_q;
    logic [16:0]                   wcnt_q;
    logic [ADDR_WIDTH-1:0]         addr_q;
    logic [WORD_W-1:0]             wdata_q;
    logic [NB_COL-1:0]             we_q;
    logic                          ready_q;
    logic                          core_rst_q;
    logic                          done_q;
    logic                          err_q;

    logic        accept;
    logic [15:0] len_full;
    logic [16:0] wcnt_next;

    assign accept    = s_valid_i & ready_q;
    assign len_full  = {s_data_i, len_q[7:0]};
    assign wcnt_next = wcnt_q + 17'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LD_IDLE;
            len_q      <= '0;
            csum_q     <= '0;
            bcnt_q     <= '0;
            pack_q     <= '0;
            wcnt_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= '0;
            ready_q    <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q <= '0;
            case (state_q)
                // DONE/ERR fall back to IDLE but still honour a SYNC so no byte is lost
                LD_IDLE, LD_DONE, LD_ERR: begin
                    ready_q <= 1'b1;
                    state_q <= LD_IDLE;
                    if (accept && s_data_i == SYNC_BYTE) begin
                        state_q    <= LD_LEN_LO;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        core_rst_q <= 1'b1;
                        csum_q     <= '0;
                        addr_q     <= '0;
                        wcnt_q     <= '0;
                        bcnt_q     <= '0;
                    end
                end
                LD_LEN_LO: begin
                    if (accept) begin
                        len_q[7:0] <= s_data_i;
                        csum_q     <= csum_q ^ s_data_i;
                        state_q    <= LD_LEN_HI;
                    end
                end
                LD_LEN_HI: begin
                    if (accept) begin
                        len_q[15:8] <= s_data_i;
                        csum_q      <= csum_q ^ s_data_i;
                        if ({1'b0, len_full} > MAX_LEN) begin
                            state_q <= LD_ERR;
                            err_q   <= 1'b1;
                        end else if (len_full == 16'd0) begin
                            state_q <= LD_CSUM;
                        end else begin
                            state_q <= LD_DATA;
                        end
                    end
                end
                LD_DATA: begin
                    if (accept) begin
                        csum_q <= csum_q ^ s_data_i;
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            wdata_q <= {s_data_i, pack_q};
                            we_q    <= '1;
                            ready_q <= 1'b0;
                            state_q <= LD_WRITE;
                        end else begin
                            pack_q <= {s_data_i, pack_q[WORD_W-COL_WIDTH-1:COL_WIDTH]};
                        end
                    end
                end
                // Address only advances when another word follows, so it never wraps
                LD_WRITE: begin
                    ready_q <= 1'b1;
                    wcnt_q  <= wcnt_next;
                    if (wcnt_next == {1'b0, len_q}) begin
                        state_q <= LD_CSUM;
                    end else begin
                        addr_q  <= addr_q + ADDR_WIDTH'(1);
                        state_q <= LD_DATA;
                    end
                end
                LD_CSUM: begin
                    if (accept) begin
                        if (s_data_i == csum_q) begin
                            state_q    <= LD_DONE;
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b0;
                        end else begin
                            state_q <= LD_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= LD_IDLE;
            endcase
        end
    end

    assign s_ready_o   = ready_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign core_rst_o  = core_rst_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_bram_prog_loader.sv
// Self-checking bench for bram_prog_loader: frames are parsed by a
// behavioural model and compared against the observed BRAM writes.
module tb_bram_prog_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  sData;
    logic        sValid;
    logic        sReady;
    logic [3:0]  memWe;
    logic [9:0]  memAddr;
    logic [31:0] memWdata;
    logic        coreRst;
    logic        done;
    logic        err;

    bram_prog_loader dut (
        .clk         (clk),
        .reset       (reset),
        .s_data_i    (sData),
        .s_valid_i   (sValid),
        .s_ready_o   (sReady),
        .mem_we_o    (memWe),
        .mem_addr_o  (memAddr),
        .mem_wdata_o (memWdata),
        .core_rst_o  (coreRst),
        .done_o      (done),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun  = 0;
    int testsFail = 0;
    bit gapsOn    = 0;

    logic [41:0] gotWrites[$];
    logic [41:0] expWrites[$];
    bit          expDone;
    bit          expErr;
    bit          longPulse;
    bit          badEnable;
    bit          readyInWrite;
    logic [3:0]  prevWe;
    logic [7:0]  frame[$];

    // Record every write strobe and flag malformed strobes
    always @(negedge clk) begin
        if (!reset) begin
            if (memWe != 4'h0) begin
                gotWrites.push_back({memAddr, memWdata});
                if (prevWe != 4'h0) longPulse = 1;
                if (memWe != 4'hF) badEnable = 1;
                if (sReady) readyInWrite = 1;
            end
            prevWe = memWe;
        end else begin
            prevWe = 4'h0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        assert (got === exp) else begin
            testsFail++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: walk the frame byte by byte, stopping where the stream ends
    task automatic runModel();
        int i;
        int len;
        logic [7:0] x;
        expWrites.delete();
        expDone = 0;
        expErr  = 0;
        i = 0;
        while (i < frame.size() && frame[i] != 8'hA5) i++;
        if (i >= frame.size()) return;
        i++;
        if (i + 2 > frame.size()) return;
        len = int'(frame[i]) + 256 * int'(frame[i+1]);
        x = frame[i] ^ frame[i+1];
        i += 2;
        if (len > 1024) begin
            expErr = 1;
            return;
        end
        for (int w = 0; w < len; w++) begin
            if (i + 4 > frame.size()) return;
            expWrites.push_back({10'(w), frame[i+3], frame[i+2], frame[i+1], frame[i]});
            x = x ^ frame[i] ^ frame[i+1] ^ frame[i+2] ^ frame[i+3];
            i += 4;
        end
        if (i >= frame.size()) return;
        if (frame[i] == x) expDone = 1;
        else expErr = 1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        int guard;
        if (gapsOn && $urandom_range(1) == 0) begin
            sValid = 1'b0;
            repeat ($urandom_range(2, 1)) @(negedge clk);
        end
        sValid = 1'b1;
        sData  = b;
        guard  = 0;
        while (!sReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            check("readyTimeout", 64'(guard), 64'(0));
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        sValid = 1'b0;
    endtask

    task automatic applyStimulus();
        gotWrites.delete();
        longPulse    = 0;
        badEnable    = 0;
        readyInWrite = 0;
        for (int i = 0; i < frame.size(); i++) sendByte(frame[i]);
        repeat (3) @(negedge clk);
        runModel();
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".nWrites"}, 64'(gotWrites.size()), 64'(expWrites.size()));
        for (int i = 0; i < expWrites.size() && i < gotWrites.size(); i++)
            check($sformatf("%s.write%0d", tag, i), 64'(gotWrites[i]), 64'(expWrites[i]));
        check({tag, ".done"}, 64'(done), 64'(expDone));
        check({tag, ".err"}, 64'(err), 64'(expErr));
        check({tag, ".coreRst"}, 64'(coreRst), 64'(!expDone));
        check({tag, ".pulseLen"}, 64'(longPulse), 64'(0));
        check({tag, ".weAllOnes"}, 64'(badEnable), 64'(0));
        check({tag, ".readyLowInWrite"}, 64'(readyInWrite), 64'(0));
    endtask

    task automatic buildFrame(input int len, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        frame = {8'hA5, 8'(len), 8'(len >> 8)};
        x = 8'(len) ^ 8'(len >> 8);
        for (int i = 0; i < 4 * len; i++) begin
            b = 8'($urandom);
            frame.push_back(b);
            x = x ^ b;
        end
        frame.push_back(corrupt ? x + 8'd1 : x);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        sValid = 1'b0;
        sData  = 8'h00;
        prevWe = 4'h0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst.ready", 64'(sReady), 64'(0));
        check("rst.we", 64'(memWe), 64'(0));
        check("rst.addr", 64'(memAddr), 64'(0));
        check("rst.wdata", 64'(memWdata), 64'(0));
        check("rst.coreRst", 64'(coreRst), 64'(1));
        check("rst.done", 64'(done), 64'(0));
        check("rst.err", 64'(err), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("rst.readyAfter", 64'(sReady), 64'(1));
        check("rst.coreRstAfter", 64'(coreRst), 64'(1));

        // Two-word frame with a good checksum
        frame = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'hB7, 8'h00, 8'h10, 8'h00, 8'hB6};
        applyStimulus();
        check("good.expectDone", 64'(expDone), 64'(1));
        checkOutput("good");

        // Next SYNC re-asserts core reset and clears done
        frame = {8'hA5};
        applyStimulus();
        check("resync.coreRst", 64'(coreRst), 64'(1));
        check("resync.done", 64'(done), 64'(0));
        pulseReset();

        // Same frame, checksum off by one
        frame = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'hB7, 8'h00, 8'h10, 8'h00, 8'hB7};
        applyStimulus();
        checkOutput("badCsum");

        // Oversized length aborts right after LEN_HI
        frame = {8'hA5, 8'h01, 8'h04};
        applyStimulus();
        checkOutput("tooLong");

        // Zero-length frame carries only the checksum
        frame = {8'hA5, 8'h00, 8'h00, 8'h00};
        applyStimulus();
        checkOutput("zeroLen");

        // Prefix junk and random valid gaps
        gapsOn = 1;
        frame = {8'h00, 8'h55, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'hB7, 8'h00, 8'h10, 8'h00, 8'hB6};
        applyStimulus();
        checkOutput("gaps");

        // Random frames, the last with a corrupted checksum
        for (int n = 0; n < 4; n++) begin
            buildFrame(int'($urandom_range(6, 1)), n == 3);
            applyStimulus();
            checkOutput($sformatf("rand%0d", n));
        end
        gapsOn = 0;

        // Reset after 6 data bytes, then a full frame
        frame = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        applyStimulus();
        check("partial.nWrites", 64'(gotWrites.size()), 64'(expWrites.size()));
        pulseReset();
        check("partial.coreRst", 64'(coreRst), 64'(1));
        check("partial.ready", 64'(sReady), 64'(1));
        frame = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'hB7, 8'h00, 8'h10, 8'h00, 8'hB6};
        applyStimulus();
        checkOutput("afterReset");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
